mem_arbiter: RTL

- Sequences the single byte-wide unified RAM port between two requesters: the instruction-fetch port (address from the PC register) and the MEM-stage data port.
- Assembles 32-bit instruction words and byte/half/word data accesses from sequential byte cycles.
- Raises per-stage stall requests; the pipeline controller folds these into the 6-bit stall vector that freezes the PC and the pipeline registers.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified byte-wide RAM arbiter.
// Latency: none (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIfRd  = 2'd1,
        StMemRd = 2'd2,
        StMemWr = 2'd3
    } arb_state_t;

    // Data access width codes; 2'b11 decodes as a word
    localparam logic [1:0] MemByte = 2'b00;
    localparam logic [1:0] MemHalf = 2'b01;
    localparam logic [1:0] MemWord = 2'b10;

    // Byte counter must reach 4 (the done cycle of a word read)
    localparam int MemArbLatW = 3;
    typedef logic [MemArbLatW-1:0] lat_cnt_t;

endpackage

// File: rtl/mem_arbiter.sv
// Sequences one byte-wide RAM port between instruction fetch and MEM-stage data accesses.
// Latency: reads finish N+1 cycles after the grant cycle, writes N cycles after (N = 1/2/4 bytes).
// Backpressure: requesters hold req and see stall_req_* until their one-cycle done pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_width,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              stall_req_if,
    output logic              stall_req_mem
);

    // Bytes moved by one access of the given width
    function automatic lat_cnt_t nbytes(input logic [1:0] w);
        case (w)
            MemByte: return lat_cnt_t'(1);
            MemHalf: return lat_cnt_t'(2);
            default: return lat_cnt_t'(4);
        endcase
    endfunction

    arb_state_t        state_q, state_n;
    lat_cnt_t          cnt_q, cnt_n;
    logic [ADDR_W-1:0] base_q, base_n;
    logic [1:0]        width_q, width_n;
    logic [31:0]       wdata_q, wdata_n;
    logic [31:0]       buf_q;
    logic              done_q, done_n;
    logic              grant;
    lat_cnt_t          n_q, n_n;
    logic [ADDR_W-1:0] ram_addr_n;
    logic              ram_wr_n;
    logic [7:0]        ram_dout_n;
    logic [31:0]       rd_word;
    logic              is_rd_q;

    assign n_q     = nbytes(width_q);
    assign is_rd_q = (state_q == StIfRd) || (state_q == StMemRd);

    // Next-state: grant in IDLE (data port first), step the byte counter, exit on done or fetch flush
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        base_n  = base_q;
        width_n = width_q;
        wdata_n = wdata_q;
        grant   = 1'b0;
        case (state_q)
            StIdle: begin
                if (mem_req) begin
                    state_n = mem_we ? StMemWr : StMemRd;
                    base_n  = mem_addr;
                    width_n = mem_width;
                    wdata_n = mem_wdata;
                    cnt_n   = '0;
                    grant   = 1'b1;
                end else if (if_req) begin
                    state_n = StIfRd;
                    base_n  = if_addr;
                    width_n = MemWord;
                    cnt_n   = '0;
                    grant   = 1'b1;
                end
            end
            StIfRd: begin
                if (flush || done_q) begin
                    state_n = StIdle;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + lat_cnt_t'(1);
                end
            end
            default: begin
                if (done_q) begin
                    state_n = StIdle;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + lat_cnt_t'(1);
                end
            end
        endcase
    end

    assign n_n = nbytes(width_n);

    // Next values of the registered RAM-side outputs and the done flag
    always_comb begin
        ram_addr_n = ram_addr;
        ram_dout_n = ram_dout;
        ram_wr_n   = (state_n == StMemWr);
        // Addresses go out only for byte slots 0..N-1; the read done cycle keeps the last one
        if (state_n != StIdle && cnt_n < n_n) begin
            ram_addr_n = base_n + ADDR_W'(cnt_n);
        end
        if (state_n == StMemWr) begin
            ram_dout_n = 8'(wdata_n >> {cnt_n[1:0], 3'b000});
        end
        // Writes finish with the last byte strobe; reads one cycle later when the last byte returns
        done_n = ((state_n == StMemWr) && (cnt_n == n_n - lat_cnt_t'(1))) ||
                 (((state_n == StIfRd) || (state_n == StMemRd)) && (cnt_n == n_n));
    end

    // FSM, latched request and RAM-side output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            base_q   <= '0;
            width_q  <= MemByte;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            ram_addr <= '0;
            ram_wr   <= 1'b0;
            ram_dout <= '0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            base_q   <= base_n;
            width_q  <= width_n;
            wdata_q  <= wdata_n;
            done_q   <= done_n;
            ram_addr <= ram_addr_n;
            ram_wr   <= ram_wr_n;
            ram_dout <= ram_dout_n;
        end
    end

    // Collect read bytes 0..N-2 into their little-endian lanes; the last byte is merged live
    always_ff @(posedge clk) begin
        if (rst || grant) begin
            buf_q <= '0;
        end else if (is_rd_q && !done_q) begin
            case (cnt_q)
                lat_cnt_t'(1): buf_q[7:0]   <= ram_din;
                lat_cnt_t'(2): buf_q[15:8]  <= ram_din;
                lat_cnt_t'(3): buf_q[23:16] <= ram_din;
                default: ;
            endcase
        end
    end

    // Final read word: the byte arriving in the done cycle drops into lane N-1
    always_comb begin
        rd_word = buf_q;
        case (n_q)
            lat_cnt_t'(1): rd_word[7:0]   = ram_din;
            lat_cnt_t'(2): rd_word[15:8]  = ram_din;
            default:       rd_word[31:24] = ram_din;
        endcase
    end

    // A redirect in the fetch done cycle swallows the pulse
    assign if_done   = done_q && (state_q == StIfRd) && !flush;
    assign mem_done  = done_q && ((state_q == StMemRd) || (state_q == StMemWr));
    assign if_data   = if_done ? rd_word : 32'h0;
    assign mem_rdata = (mem_done && (state_q == StMemRd)) ? rd_word : 32'h0;

    assign stall_req_if  = if_req && !if_done;
    assign stall_req_mem = mem_req && !mem_done;

endmodule
